// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package reset_seq_pkg;

    localparam int unsigned MAX_DOMAINS = 16;
    localparam int unsigned IDX_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        WAIT_RDY,
        GAP
    } state_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_DOMAINS-1:0] vec);
        logic [IDX_W-1:0] pos;
        pos = '0;
        for (int i = MAX_DOMAINS - 1; i >= 0; i--) begin
            if (vec[i]) pos = IDX_W'(i);
        end
        return pos;
    endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Up-counter shared by hold, gap and timeout phases; stops at its terminal value.
module reset_seq_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         at_limit_c
);

    logic [W-1:0] count;

    assign at_limit_c = (count == limit);

    // Holding at the limit keeps the terminal count from ever wrapping.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (!at_limit_c) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: releases masked reset domains one at a time in
// ascending order, each waiting on ready or timeout, separated by a fixed gap.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = 4,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic [NUM_DOMAINS-1:0] req_mask,
    output logic [NUM_DOMAINS-1:0] dom_reset,
    input  logic [NUM_DOMAINS-1:0] dom_ready,
    output logic                   busy,
    output logic                   all_up,
    output logic [NUM_DOMAINS-1:0] err
);

    localparam int unsigned MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    function automatic logic [NUM_DOMAINS-1:0] onehot(input logic [IDX_W-1:0] pos);
        return NUM_DOMAINS'(MAX_DOMAINS'(1) << pos);
    endfunction

    state_t                 state;
    state_t                 state_nx;
    logic [NUM_DOMAINS-1:0] act;
    logic [NUM_DOMAINS-1:0] act_nx;
    logic [NUM_DOMAINS-1:0] dom_reset_nx;
    logic [NUM_DOMAINS-1:0] err_nx;
    logic [NUM_DOMAINS-1:0] cur_oh;
    logic [NUM_DOMAINS-1:0] act_left;
    logic [NUM_DOMAINS-1:0] first_oh;
    logic [NUM_DOMAINS-1:0] next_oh;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_nx;
    logic [IDX_W-1:0]       first_idx;
    logic [IDX_W-1:0]       next_idx;
    logic [CNT_W-1:0]       limit;
    logic                   tmr_last;
    logic                   tmr_clr;
    logic                   fire;
    logic                   ready_hit;
    logic                   leave;
    logic                   req_rdy_nx;
    logic                   busy_nx;
    logic                   all_up_nx;

    assign fire      = req_val && (state == IDLE);
    assign cur_oh    = onehot(idx);
    assign ready_hit = |(dom_ready & cur_oh);
    assign leave     = (state == WAIT_RDY) && (ready_hit || tmr_last);
    assign act_left  = act & ~cur_oh;
    assign first_idx = lowest_set(MAX_DOMAINS'(act));
    assign first_oh  = onehot(first_idx);
    assign next_idx  = lowest_set(MAX_DOMAINS'(act_left));
    assign next_oh   = onehot(next_idx);

    always_comb begin
        limit = '0;
        case (state)
            ASSERT:   limit = HOLD_LAST;
            WAIT_RDY: limit = TMO_LAST;
            GAP:      limit = GAP_LAST;
            default:  limit = '0;
        endcase
    end

    reset_seq_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clr        (tmr_clr),
        .limit      (limit),
        .at_limit_c (tmr_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ASSERT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (fire && (req_mask != '0)) state_nx = ASSERT;
            end
            ASSERT: begin
                if (tmr_last) state_nx = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (leave) begin
                    if (act_left == '0)       state_nx = IDLE;
                    else if (GAP_CYCLES == 0) state_nx = WAIT_RDY;
                    else                      state_nx = GAP;
                end
            end
            GAP: begin
                if (tmr_last) state_nx = WAIT_RDY;
            end
            default: state_nx = ASSERT;
        endcase
    end

    // Datapath and output next values; outputs are registered from these.
    always_comb begin
        act_nx       = act;
        idx_nx       = idx;
        dom_reset_nx = dom_reset;
        err_nx       = err;
        tmr_clr      = (state_nx != state);
        case (state)
            IDLE: begin
                if (fire && (req_mask != '0)) begin
                    act_nx       = req_mask;
                    dom_reset_nx = dom_reset | req_mask;
                    err_nx       = err & ~req_mask;
                end
            end
            ASSERT, GAP: begin
                if (tmr_last) begin
                    idx_nx       = first_idx;
                    dom_reset_nx = dom_reset & ~first_oh;
                end
            end
            WAIT_RDY: begin
                if (leave) begin
                    act_nx = act_left;
                    if (!ready_hit) err_nx = err | cur_oh;
                    // With no gap the next domain is released straight away.
                    if ((GAP_CYCLES == 0) && (act_left != '0)) begin
                        idx_nx       = next_idx;
                        dom_reset_nx = dom_reset & ~next_oh;
                        tmr_clr      = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        req_rdy_nx = (state_nx == IDLE);
        busy_nx    = (state_nx != IDLE);
        all_up_nx  = (state_nx == IDLE) && (dom_reset_nx == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act       <= '1;
            idx       <= '0;
            dom_reset <= '1;
            err       <= '0;
            req_rdy   <= 1'b0;
            busy      <= 1'b1;
            all_up    <= 1'b0;
        end else begin
            act       <= act_nx;
            idx       <= idx_nx;
            dom_reset <= dom_reset_nx;
            err       <= err_nx;
            req_rdy   <= req_rdy_nx;
            busy      <= busy_nx;
            all_up    <= all_up_nx;
        end
    end

endmodule
